// File: rtl/cla_pipe_addsub_pkg.sv
// rtl/cla_pipe_addsub_pkg.sv - shared types and lookahead helper for the pipelined CLA
//
// Package cla_pkg
//   GRP_W       : width of one lookahead group (4 bits)
//   grp_res_t   : result of one group {sum nibble, carry out, group G, group P}
//   cla_carries : lookahead carries c1..c4 of a group from bit g, p and carry in
package cla_pkg;

  localparam int GRP_W = 4;

  typedef struct packed {
    logic [GRP_W-1:0] sum;
    logic             cout;
    logic             g;
    logic             p;
  } grp_res_t;

  // Bit i of the result is the carry into bit i+1 (c1..c4), each written
  // out as a flat sum of products so no carry depends on another.
  function automatic logic [GRP_W-1:0] cla_carries(input logic [GRP_W-1:0] g,
                                                   input logic [GRP_W-1:0] p,
                                                   input logic             cin);
    logic [GRP_W-1:0] c;
    c[0] = g[0] | (p[0] & cin);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

endpackage

// File: rtl/cla_pipe_addsub_grp4.sv
// rtl/cla_pipe_addsub_grp4.sv - combinational 4-bit carry-lookahead group
//
// Module cla_grp4
//   a, b : operand nibbles (b already inverted for subtraction)
//   cin  : carry into the group
//   res  : {sum nibble, carry out, group generate G, group propagate P}
module cla_grp4
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             cin,
  output grp_res_t         res
);

  logic [GRP_W-1:0] g;
  logic [GRP_W-1:0] p;
  logic [GRP_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;
  assign c = cla_carries(g, p, cin);

  // Carry into bit 0 is cin, carries into bits 1..3 are c1..c3.
  assign res.sum  = p ^ {c[2:0], cin};
  assign res.cout = c[3];
  assign res.g    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign res.p    = &p;

endmodule

// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined carry-lookahead adder/subtractor, one nibble per stage
//
// Module cla_pipe_addsub #(WIDTH)
//   clk, rst               : clock, asynchronous active-high reset
//   in_valid/in_ready      : operand handshake (a, b, cin, sub)
//   sub                    : 1 = a - b (cin ignored), 0 = a + b + cin
//   out_valid/out_ready    : result handshake (sum, cout, ovf)
//   cout                   : carry out of the MSB (1 = no borrow on subtract)
//   ovf                    : two's-complement signed overflow
// Optional build macro CLA_PIPE_SAT_EN: saturate sum to the signed limit on overflow.
//
// Rank 0 registers the prepared operands at acceptance. Stage k reads rank k,
// resolves nibble k and writes rank k+1; the last stage writes the output
// register, so a beat accepted at edge N is visible after edge N+NUM_GRP.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NUM_GRP = WIDTH / GRP_W;
  localparam int LAST    = NUM_GRP - 1;

  if (((WIDTH % GRP_W) != 0) || (WIDTH < GRP_W)) begin : g_width_check
    $error("cla_pipe_addsub: WIDTH must be a multiple of 4 and at least 4");
  end

  // aw[k]: nibbles below k already hold sum bits, nibbles k and up still hold A.
  // bw[k]: effective B; only nibbles k and up are still read downstream.
  logic [WIDTH-1:0]   aw     [NUM_GRP];
  logic [WIDTH-1:0]   bw     [NUM_GRP];
  logic               c      [NUM_GRP];
  logic [NUM_GRP:0]   v;

  logic [WIDTH-1:0]   aw_nxt [NUM_GRP];
  logic [GRP_W-1:0]   s_nib  [NUM_GRP];
  logic               co     [NUM_GRP];

  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;

  logic               en;
  logic               c_msb;
  logic               ovf_nxt;
  logic [WIDTH-1:0]   sum_fin;

  assign en        = !v[NUM_GRP] || out_ready;
  assign in_ready  = en;
  assign out_valid = v[NUM_GRP];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  for (genvar k = 0; k < NUM_GRP; k++) begin : g_stage
    grp_res_t res;
    logic     unused_gp;

    cla_grp4 u_grp (
      .a   (aw[k][GRP_W*k +: GRP_W]),
      .b   (bw[k][GRP_W*k +: GRP_W]),
      .cin (c[k]),
      .res (res)
    );

    // Splice the freshly resolved nibble into the travelling word.
    assign aw_nxt[k] = (aw[k] & ~(WIDTH'({GRP_W{1'b1}}) << (GRP_W*k)))
                     | (WIDTH'(res.sum) << (GRP_W*k));
    assign s_nib[k]  = res.sum;
    assign co[k]     = res.cout;

    // Group G/P are only needed by a two-level lookahead tree, not by the
    // registered ripple between stages.
    assign unused_gp = res.g ^ res.p;
  end

  // Carry into the MSB recovered from the MSB's own sum bit: s = a ^ b ^ c.
  assign c_msb   = s_nib[LAST][GRP_W-1] ^ aw[LAST][WIDTH-1] ^ bw[LAST][WIDTH-1];
  assign ovf_nxt = c_msb ^ co[LAST];

`ifdef CLA_PIPE_SAT_EN
  // aw[LAST] still holds A's top nibble here, so its MSB gives the direction.
  always_comb begin
    sum_fin = aw_nxt[LAST];
    if (ovf_nxt) begin
      sum_fin = aw[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum_fin = aw_nxt[LAST];
`endif

  // Nibbles of B below the last group are dead by the final stage.
  logic unused_bw;
  assign unused_bw = ^bw[LAST];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k < NUM_GRP; k++) begin
        aw[k] <= '0;
        bw[k] <= '0;
        c[k]  <= 1'b0;
      end
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (en) begin
      // Valid bits shift in lockstep; bubbles are carried, not squeezed.
      v     <= {v[NUM_GRP-1:0], in_valid};
      aw[0] <= a;
      bw[0] <= sub ? ~b : b;
      c[0]  <= sub | cin;
      for (int k = 1; k < NUM_GRP; k++) begin
        aw[k] <= aw_nxt[k-1];
        bw[k] <= bw[k-1];
        c[k]  <= co[k-1];
      end
      // Output keeps the last real result across bubbles.
      if (v[LAST]) begin
        sum_q  <= sum_fin;
        cout_q <= co[LAST];
        ovf_q  <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - self-checking bench for cla_pipe_addsub at WIDTH=16
module tb_cla_pipe_addsub;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  localparam logic [15:0] OVF_SUM =
`ifdef CLA_PIPE_SAT_EN
    16'h7FFF;
`else
    16'h8000;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  exp_t sb[$];

  cla_pipe_addsub #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb_);
    logic [15:0] yy;
    logic [16:0] f;
    exp_t        r;
    yy   = sb_ ? ~y : y;
    f    = {1'b0, x} + {1'b0, yy} + {16'b0, (sb_ ? 1'b1 : ci)};
    r.s  = f[15:0];
    r.co = f[16];
    r.ov = (x[15] == yy[15]) && (f[15] != x[15]);
`ifdef CLA_PIPE_SAT_EN
    if (r.ov) r.s = x[15] ? 16'h8000 : 16'h7FFF;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on every accept, pop and compare on every output transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) sb.push_back(model(a, b, cin, sub));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("cout", 32'(cout), 32'(e.co));
          chk("ovf", 32'(ovf), 32'(e.ov));
          n_out++;
        end
      end
    end
  end

  task automatic drive(input logic [15:0] xa, input logic [15:0] xb,
                       input logic xc, input logic xs);
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
  endtask

  task automatic send(input logic [15:0] xa, input logic [15:0] xb,
                      input logic xc, input logic xs, output int cycles);
    logic ok;
    cycles = 0;
    drive(xa, xb, xc, xs);
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      cycles++;
    end while (!ok && cycles < 50);
    chk("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(n < 60), 32'd1);
  endtask

  // Single beat into an empty pipe; out_valid must rise exactly after edge N+4.
  task automatic lat_beat(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                          input logic xs, input logic [15:0] es, input logic ec,
                          input logic eo);
    out_ready = 1'b1;
    drive(xa, xb, xc, xs);
    @(negedge clk);
    chk("lat_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk("lat_valid", 32'(out_valid), 32'(i == 4));
    end
    chk("lat_sum", 32'(sum), 32'(es));
    chk("lat_cout", 32'(cout), 32'(ec));
    chk("lat_ovf", 32'(ovf), 32'(eo));
  endtask

  initial begin
    int   cyc;
    int   acc_cycles;
    int   idx;
    int   n0;
    logic acc_now;
    logic seen;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Carry ripples through every group.
    lat_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    wait_drain();

    // Positive signed overflow.
    lat_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, OVF_SUM, 1'b0, 1'b1);
    wait_drain();

    // Subtraction with borrow, negative overflow, cin use and cin ignored on sub.
    send(16'h0005, 16'h0007, 1'b0, 1'b1, cyc);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, cyc);
    send(16'h1234, 16'h0FFF, 1'b1, 1'b0, cyc);
    send(16'h0010, 16'h0001, 1'b1, 1'b1, cyc);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, cyc);
    in_valid = 1'b0;
    wait_drain();

    // Backpressure: the pipe fills, stalls and holds the head result.
    out_ready = 1'b0;
    idx = 0;
    drive(16'(idx), 16'h0010, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        idx++;
        if (idx < 6) drive(16'(idx), 16'h0010, 1'b0, 1'b0);
        else in_valid = 1'b0;
      end
    end
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_sum", 32'(sum), 32'h10);
    chk("bp_stalled", 32'(idx < 6), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hold_sum", 32'(sum), 32'h10);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    n0 = n_out;
    out_ready = 1'b1;
    for (int k = 0; k < 30 && idx < 6; k++) begin
      @(negedge clk);
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        idx++;
        if (idx < 6) drive(16'(idx), 16'h0010, 1'b0, 1'b0);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    wait_drain();
    chk("bp_count", 32'(n_out - n0), 32'd6);

    // Full-rate random stream: every beat accepted on its first cycle.
    out_ready = 1'b1;
    acc_cycles = 0;
    n0 = n_out;
    for (int k = 0; k < 100; k++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), cyc);
      acc_cycles += cyc;
    end
    in_valid = 1'b0;
    chk("full_rate_cycles", 32'(acc_cycles), 32'd100);
    wait_drain();
    chk("stream_count", 32'(n_out - n0), 32'd100);

    // Reset with three beats in flight, head held at the output.
    out_ready = 1'b0;
    send(16'h0101, 16'h0202, 1'b0, 1'b0, cyc);
    send(16'h0303, 16'h0404, 1'b0, 1'b0, cyc);
    send(16'h0505, 16'h0606, 1'b0, 1'b0, cyc);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_sum", 32'(sum), 32'd0);
    sb.delete();
    #3 rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale_out", 32'(seen), 32'd0);
    lat_beat(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
